// File: rtl/qr_pkg.sv
// qr_pkg: shared constants, direction codes and state encoding for the QR array stages
package qr_pkg;
    localparam int W  = 13;
    localparam int KW = 9;
    localparam logic [KW-1:0] K = 9'b010011011;
    localparam logic [1:0] SIGN_POS = 2'b01;
    localparam logic [1:0] SIGN_NEG = 2'b11;
    typedef enum logic [2:0] {
        FIRST = 3'b001,
        SEC   = 3'b010,
        THIRD = 3'b100
    } state_e;
    // A code means "rotate by -1" whenever its upper bit is set.
    function automatic logic is_neg(input logic [1:0] c);
        return (c | SIGN_POS) == SIGN_NEG;
    endfunction
endpackage

// File: rtl/gr_micro4.sv
// gr_micro4: four chained CORDIC micro-rotations starting at shift sh_i
module gr_micro4
    import qr_pkg::*;
(
    input  logic signed [W-1:0] x_i,
    input  logic signed [W-1:0] y_i,
    input  logic [7:0]          d_sign_i,
    input  logic [3:0]          sh_i,
    output logic signed [W-1:0] x_o,
    output logic signed [W-1:0] y_o
);
    logic signed [W-1:0] xa, ya, dx, dy;
    logic [3:0] sh;
    // Each step rotates using the pre-step pair; code i drives shift sh_i+i.
    always_comb begin
        xa = x_i;
        ya = y_i;
        sh = '0;
        dx = '0;
        dy = '0;
        for (int i = 0; i < 4; i++) begin
            sh = sh_i + 4'(i);
            dx = ya >>> sh;
            dy = xa >>> sh;
            xa = is_neg(d_sign_i[2*i +: 2]) ? xa + dx : xa - dx;
            ya = is_neg(d_sign_i[2*i +: 2]) ? ya - dy : ya + dy;
        end
        x_o = xa;
        y_o = ya;
    end
endmodule

// File: rtl/gr_rotate.sv
// gr_rotate: 12-step CORDIC rotation over 3 cycles, then gain scaling (GR_ROUND_EN selects rounding)
module gr_rotate
    import qr_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic signed [W-1:0] x,
    input  logic signed [W-1:0] y,
    input  logic [7:0]          d_sign,
    output logic signed [W-1:0] GR_Xout,
    output logic signed [W-1:0] GR_Yout,
    output logic                fin,
    output logic                busy
);
`ifdef GR_ROUND_EN
    localparam logic signed [21:0] RND = 22'sd128;
`else
    localparam logic signed [21:0] RND = 22'sd0;
`endif
    localparam logic signed [KW-1:0] KS = $signed(K);

    state_e state_q, state_d;
    logic signed [W-1:0] x_q, y_q, xo_q, yo_q;
    logic signed [W-1:0] ax, ay, mx, my, sx, sy;
    logic signed [21:0] px, py;
    logic [3:0] sh;
    logic fin_q, busy_q;

    gr_micro4 u_micro (
        .x_i      (ax),
        .y_i      (ay),
        .d_sign_i (d_sign),
        .sh_i     (sh),
        .x_o      (mx),
        .y_o      (my)
    );

    // Operand select, shift base, next state and final gain scaling.
    always_comb begin
        ax = state_q == FIRST ? x : x_q;
        ay = state_q == FIRST ? y : y_q;
        sh = state_q == FIRST ? 4'd0 : state_q == SEC ? 4'd4 : 4'd8;
        state_d = !en ? FIRST : state_q == FIRST ? SEC : state_q == SEC ? THIRD : FIRST;
        px = 22'(mx) * 22'(KS) + RND;
        py = 22'(my) * 22'(KS) + RND;
        sx = W'(px >>> 8);
        sy = W'(py >>> 8);
    end

    // Sequencer plus accumulator and registered result/handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FIRST;
            x_q     <= '0;
            y_q     <= '0;
            xo_q    <= '0;
            yo_q    <= '0;
            fin_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= state_d != FIRST;
            fin_q   <= en && state_q == THIRD;
            if (en) begin
                x_q <= mx;
                y_q <= my;
            end
            if (en && state_q == THIRD) begin
                xo_q <= sx;
                yo_q <= sy;
            end
        end
    end

    assign GR_Xout = xo_q;
    assign GR_Yout = yo_q;
    assign fin     = fin_q;
    assign busy    = busy_q;
endmodule

// File: tb/tb_gr_rotate.sv
// tb_gr_rotate: randomized self-checking bench for gr_rotate against an arithmetic CORDIC model
module tb_gr_rotate;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0;
    logic signed [12:0] x = '0, y = '0;
    logic [7:0] d_sign = '0;
    logic signed [12:0] GR_Xout, GR_Yout;
    logic fin, busy;
    int errs = 0;
    int checks = 0;

`ifdef GR_ROUND_EN
    localparam int RND = 128;
    localparam int EXP_Y = -248;
`else
    localparam int RND = 0;
    localparam int EXP_Y = -249;
`endif

    gr_rotate dut (
        .clk(clk), .rst(rst), .en(en), .x(x), .y(y), .d_sign(d_sign),
        .GR_Xout(GR_Xout), .GR_Yout(GR_Yout), .fin(fin), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation ran past time limit");
        $fatal(1);
    end

    function automatic int fdiv(input int a, input int b);
        return a >= 0 ? a / b : -((-a + b - 1) / b);
    endfunction

    function automatic int wrap13(input int v);
        logic [12:0] t;
        t = v[12:0];
        return int'($signed(t));
    endfunction

    task automatic model(input int xa, input int ya, input logic [23:0] d, output int rx, output int ry);
        int cx, cy, nx, s;
        cx = xa;
        cy = ya;
        for (int i = 0; i < 12; i++) begin
            s = d[2*i+1] ? -1 : 1;
            nx = wrap13(cx - s * fdiv(cy, 1 << i));
            cy = wrap13(cy + s * fdiv(cx, 1 << i));
            cx = nx;
        end
        rx = wrap13(fdiv(cx * 155 + RND, 256));
        ry = wrap13(fdiv(cy * 155 + RND, 256));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic signed [12:0] xa, input logic signed [12:0] ya,
                         input logic [23:0] d, input bit last, output int rx, output int ry);
        model(int'(xa), int'(ya), d, rx, ry);
        en = 1'b1;
        x = xa;
        y = ya;
        d_sign = d[7:0];
        step();
        checks++; if (busy !== 1'b1 || fin !== 1'b0) begin errs++; $display("FAIL op_cyc1 busy=%b fin=%b want busy=1 fin=0", busy, fin); end
        x = 13'($urandom);
        y = 13'($urandom);
        d_sign = d[15:8];
        step();
        checks++; if (busy !== 1'b1 || fin !== 1'b0) begin errs++; $display("FAIL op_cyc2 busy=%b fin=%b want busy=1 fin=0", busy, fin); end
        d_sign = d[23:16];
        step();
        checks++; if (fin !== 1'b1 || busy !== 1'b0) begin errs++; $display("FAIL op_fin fin=%b busy=%b want fin=1 busy=0", fin, busy); end
        checks++; if (int'(GR_Xout) != rx || int'(GR_Yout) != ry) begin errs++; $display("FAIL op_result got (%0d,%0d) want (%0d,%0d) x=%0d y=%0d d=%h", GR_Xout, GR_Yout, rx, ry, xa, ya, d); end
        if (last) begin
            en = 1'b0;
            step();
            checks++; if (fin !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL op_after fin=%b busy=%b want 0 0", fin, busy); end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        checks++; if (GR_Xout !== 13'sd0) begin errs++; $display("FAIL reset_x got %0d want 0", GR_Xout); end
        checks++; if (GR_Yout !== 13'sd0) begin errs++; $display("FAIL reset_y got %0d want 0", GR_Yout); end
        checks++; if (fin !== 1'b0) begin errs++; $display("FAIL reset_fin got %b want 0", fin); end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_scaling();
        int rx, ry;
        do_op(13'sd256, 13'sd0, 24'hFFFFFF, 1'b1, rx, ry);
        step();
        checks++; if (int'(GR_Xout) != -47 || int'(GR_Yout) != EXP_Y) begin errs++; $display("FAIL scaling got (%0d,%0d) want (-47,%0d)", GR_Xout, GR_Yout, EXP_Y); end
    endtask

    task automatic test_zero();
        int rx, ry;
        do_op(13'sd0, 13'sd0, 24'($urandom), 1'b1, rx, ry);
        checks++; if (GR_Xout !== 13'sd0 || GR_Yout !== 13'sd0) begin errs++; $display("FAIL zero got (%0d,%0d) want (0,0)", GR_Xout, GR_Yout); end
    endtask

    task automatic test_random();
        int rx, ry;
        logic [23:0] d;
        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < 12; i++) d[2*i +: 2] = $urandom_range(0, 1) ? 2'b11 : 2'b01;
            if (n % 5 == 4) d = 24'($urandom);
            do_op(13'($urandom), 13'($urandom), d, 1'b1, rx, ry);
        end
    endtask

    task automatic test_abort();
        logic signed [12:0] px, py;
        int rx, ry;
        px = GR_Xout;
        py = GR_Yout;
        en = 1'b1;
        x = 13'sd1000;
        y = -13'sd700;
        d_sign = 8'h5D;
        step();
        step();
        en = 1'b0;
        step();
        checks++; if (fin !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL abort_flags fin=%b busy=%b want 0 0", fin, busy); end
        checks++; if (GR_Xout !== px || GR_Yout !== py) begin errs++; $display("FAIL abort_hold got (%0d,%0d) want (%0d,%0d)", GR_Xout, GR_Yout, px, py); end
        step();
        checks++; if (fin !== 1'b0) begin errs++; $display("FAIL abort_nofin got %b want 0", fin); end
        do_op(13'sd1000, -13'sd700, 24'hD75D3F, 1'b1, rx, ry);
    endtask

    task automatic test_back_to_back();
        int rx, ry;
        do_op(13'sd256, 13'sd0, 24'hFFFFFF, 1'b0, rx, ry);
        checks++; if (int'(GR_Xout) != -47 || int'(GR_Yout) != EXP_Y) begin errs++; $display("FAIL b2b_op1 got (%0d,%0d) want (-47,%0d)", GR_Xout, GR_Yout, EXP_Y); end
        do_op(13'sd0, 13'sd0, 24'hFFFFFF, 1'b0, rx, ry);
        checks++; if (GR_Xout !== 13'sd0 || GR_Yout !== 13'sd0) begin errs++; $display("FAIL b2b_op2 got (%0d,%0d) want (0,0)", GR_Xout, GR_Yout); end
        do_op(-13'sd1234, 13'sd2047, 24'($urandom), 1'b1, rx, ry);
    endtask

    task automatic test_async_reset();
        int rx, ry;
        en = 1'b1;
        x = 13'sd300;
        y = 13'sd200;
        d_sign = 8'hFF;
        step();
        #2;
        rst = 1'b0;
        #1;
        checks++; if (GR_Xout !== 13'sd0 || GR_Yout !== 13'sd0) begin errs++; $display("FAIL areset_out got (%0d,%0d) want (0,0)", GR_Xout, GR_Yout); end
        checks++; if (fin !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL areset_flags fin=%b busy=%b want 0 0", fin, busy); end
        en = 1'b0;
        step();
        rst = 1'b1;
        step();
        checks++; if (fin !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL areset_idle fin=%b busy=%b want 0 0", fin, busy); end
        do_op(13'sd256, 13'sd0, 24'hFFFFFF, 1'b1, rx, ry);
        checks++; if (int'(GR_Xout) != -47 || int'(GR_Yout) != EXP_Y) begin errs++; $display("FAIL areset_op got (%0d,%0d) want (-47,%0d)", GR_Xout, GR_Yout, EXP_Y); end
    endtask

    initial begin
        test_reset();
        test_scaling();
        test_zero();
        test_random();
        test_abort();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/gr_rotate.md
Name: gr_rotate

Overview:
- Givens-rotation (GR) stage, directly downstream of the GG vectoring stage in the QR array.
- Applies the 12 CORDIC micro-rotation directions produced by GG (as `d_sign`, 4 per cycle over 3 cycles) to another 13-bit column pair (x, y).
- Scales the result by the CORDIC gain constant and presents the rotated pair with a one-cycle `fin` pulse.
- `en` is driven by GG's `next_en`, so sign group n arrives in the same cycle GR processes group n.

Parameters:
- W, 13, operand/result width (signed).
- KW, 9, gain-constant width.
- K, 9'b010011011, CORDIC gain constant (155/256, about 0.6055).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- en  input  1  operation enable; must stay high for 3 consecutive cycles per operation.
- x  input  W  signed x operand; sampled only in state FIRST.
- y  input  W  signed y operand; sampled only in state FIRST.
- d_sign  input  8  four 2-bit direction codes for the current group; bits [1:0] first … [7:6] last.
- GR_Xout  output  W  rotated, scaled x.
- GR_Yout  output  W  rotated, scaled y.
- fin  output  1  one-cycle pulse: GR_Xout/GR_Yout updated.
- busy  output  1  high while in SEC or THIRD.

Behaviour:
- Reset (rst=0, asynchronous): state=FIRST; GR_Xout=0, GR_Yout=0, fin=0, busy=0; internal x/y accumulators cleared.
- States and transitions:
  - FIRST → SEC when en=1.
  - SEC → THIRD when en=1.
  - THIRD → FIRST unconditionally.
  - Any state → FIRST when en=0; the partial result is discarded and outputs are unchanged.
- Direction decode: code bit[1]=0 means +1; bit[1]=1 means -1. GG emits 2'b01 / 2'b11.
- Micro-rotation i with direction s:
  - x' = x − s·(y >>> i)
  - y' = y + s·(x >>> i)
  - Arithmetic shifts, W-bit wrap, no saturation.
  - Both updates use pre-step values.
- Per-state work, four chained steps each:
  - FIRST (en=1): load x, y; apply shifts 0..3 using d_sign codes in order [1:0],[3:2],[5:4],[7:6]; register the result.
  - SEC: apply shifts 4..7 to the registered pair.
  - THIRD: apply shifts 8..11, then compute a 22-bit signed product with K and take bits [20:8] (floor); register into GR_Xout/GR_Yout.
- fin=1 in the cycle after THIRD, for exactly 1 cycle; otherwise 0.
- Latency: x/y sampled at cycle 0 edge; result and fin visible after the cycle-2 edge, i.e. 3 cycles.
- Back-to-back: en held high restarts FIRST in the cycle after THIRD and reloads x/y.
  - The fin pulse of operation n coincides with FIRST of operation n+1.
  - Throughput is 1 result per 3 cycles.
- busy=1 exactly while state is SEC or THIRD (registered from next_state).
- Reset asserted mid-operation: immediate return to FIRST with reset values; no fin.

Optional Feature:
- Macro GR_ROUND_EN.
- Defined: round-to-nearest on final scaling; 128 is added to each 22-bit product before taking [20:8].
- Undefined: truncation (floor).
- Latency and handshake are identical in both builds.

Decomposition:
- Shared package qr_pkg:
  - W, KW, K.
  - Direction-code constants (SIGN_POS=2'b01, SIGN_NEG=2'b11).
  - State encoding FIRST/SEC/THIRD (3-bit), shared with GG.
- One sub-module, gr_micro4: combinational chain of 4 micro-rotations.
  - Inputs: x, y, 8-bit d_sign, 4-bit base shift.
  - Outputs: x, y.
  - Instantiated once and muxed by state.

Test Plan:
- Scaling, truncate build: x=256, y=0, d_sign=8'hFF for 3 cycles → after 3 cycles GR_Xout=-47, GR_Yout=-249, fin=1 for 1 cycle. Pre-scale values are -77/-410.
- Scaling, GR_ROUND_EN build: same stimulus → GR_Xout=-47, GR_Yout=-248.
- Zero input: x=0, y=0, arbitrary d_sign → outputs 0, 0; fin pulses at cycle 3; busy high in cycles 1–2.
- Early abort: en high for 2 cycles, then low → no fin, state returns to FIRST, outputs keep their previous values; the next full en burst produces a correct result.
- Back-to-back: en high for 6 cycles; op1 as in the first scenario, op2 x=0, y=0 → fin pulses at cycles 3 and 6 with (-47,-249) then (0,0).
- Reset: rst=0 during SEC of an active operation → outputs 0, fin=0, busy=0 immediately (asynchronously); after release, an operation starting with x=256, y=0, d_sign=8'hFF completes normally.
